// File: rtl/alu_flag_stage.sv
// Registered N/Z/C/V flag stage behind the add/sub datapath, exposed through a valid/ready skid buffer.
// Optional sticky carry/overflow accumulation is enabled by defining ALU_STICKY_FLAGS_EN.
module alu_flag_stage #(
    parameter int WIDTH   = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_f1,
    input  logic             in_f0,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [3:0]       out_flags,
    input  logic             clr_sticky,
    output logic [1:0]       sticky_cv
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

    state_e           state_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] main_sum_q;
    logic [WIDTH-1:0] skid_sum_q;
    logic [3:0]       main_flags_q;
    logic [3:0]       skid_flags_q;

    logic             am_msb;
    logic             bm_msb;
    logic             n_d;
    logic             z_d;
    logic             v_d;
    logic [3:0]       flags_d;
    logic             in_fire;
    logic             out_fire;

    // Only the operand sign bits feed the overflow equation; f1 masks A, f0^f1 inverts B.
    assign am_msb  = in_a[WIDTH-1] & ~in_f1;
    assign bm_msb  = in_b[WIDTH-1] ^ (in_f0 ^ in_f1);
    assign n_d     = in_sum[WIDTH-1];
    assign z_d     = ~|in_sum;
    assign v_d     = (am_msb == bm_msb) && (in_sum[WIDTH-1] != am_msb);
    assign flags_d = {n_d, z_d, in_carry, v_d};

    logic unused_lsbs;
    assign unused_lsbs = ^{in_a[WIDTH-2:0], in_b[WIDTH-2:0]};

    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = in_ready_q;
        end else begin : g_single
            // Single-entry mode trades the registered ready for a combinational out_ready->in_ready path.
            assign in_ready = !out_valid_q | out_ready;
        end
    endgenerate

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid_q & out_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = main_sum_q;
    assign out_flags = main_flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            main_sum_q   <= '0;
            main_flags_q <= '0;
            skid_sum_q   <= '0;
            skid_flags_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_sum_q   <= in_sum;
                        main_flags_q <= flags_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_sum_q   <= in_sum;
                        main_flags_q <= flags_d;
                    end else if (in_fire) begin
                        // Only reachable with SKID_EN: the single-entry ready implies out_fire here.
                        skid_sum_q   <= in_sum;
                        skid_flags_q <= flags_d;
                        in_ready_q   <= 1'b0;
                        state_q      <= TWO;
                    end else if (out_fire) begin
                        out_valid_q  <= 1'b0;
                        state_q      <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_sum_q   <= skid_sum_q;
                        main_flags_q <= skid_flags_q;
                        in_ready_q   <= 1'b1;
                        state_q      <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

`ifdef ALU_STICKY_FLAGS_EN
    logic [1:0] sticky_q;

    // Clear wins over a same-cycle handshake; that result's C/V are deliberately dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 2'b00;
        end else if (clr_sticky) begin
            sticky_q <= 2'b00;
        end else if (out_fire) begin
            sticky_q <= sticky_q | main_flags_q[1:0];
        end
    end

    assign sticky_cv = sticky_q;
`else
    logic unused_clr;
    assign unused_clr = clr_sticky;
    assign sticky_cv  = 2'b00;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && in_fire && ((z_d != in_zero) || (n_d != in_neg)))
            $error("alu_flag_stage: adder zero/neg disagree with sum %h", in_sum);
    end
`endif

endmodule
